// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the pipeline stage register: default widths and
// stage state encodings.
package pipe_stage_skid_pkg;
    localparam int REG_WIDTH      = 64;
    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_t;
endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready beat channel carrying a payload plus destination-register fields.
interface pipe_stage_skid_if #(
    parameter int DATA_W         = 64,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      valid;
    logic                      ready;
    logic [DATA_W-1:0]         data;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_write_en;

    modport master (output valid, data, rd, reg_write_en, input ready);
    modport slave  (input valid, data, rd, reg_write_en, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// One pipeline stage: valid/ready register with optional two-entry skid
// buffer, synchronous flush and a saturating downstream stall counter.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int DATA_W         = 64,
    parameter int REG_ADDR_WIDTH = pipe_stage_skid_pkg::REG_ADDR_WIDTH,
    parameter int SKID           = 1,
    parameter int CNT_W          = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    pipe_stage_skid_if.slave        up,
    pipe_stage_skid_if.master       dn,
    output logic [1:0]              occupancy,
    output logic [CNT_W-1:0]        stall_cnt
);
    localparam int ENT_W = DATA_W + REG_ADDR_WIDTH + 1;

    // Entry layout {we, rd, data}; main and skid share it so a skid->main move is a plain copy.
    stage_state_t     state_q, state_d;
    logic [ENT_W-1:0] main_q, skid_q, up_entry;
    logic             main_ld, main_from_skid;
    logic [CNT_W-1:0] stall_q;
    logic             dn_vld;

    assign up_entry = {up.reg_write_en, up.rd, up.data};
    assign dn_vld   = (state_q != ST_EMPTY);

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        unique case (state_q)
            ST_EMPTY: if (up.valid) begin
                state_d = ST_FULL;
                main_ld = 1'b1;
            end
            ST_FULL: begin
                if (up.valid && dn.ready)       main_ld = 1'b1;
                else if (up.valid && SKID != 0) state_d = ST_SKID;
                else if (!up.valid && dn.ready) state_d = ST_EMPTY;
            end
            ST_SKID: if (dn.ready) begin
                state_d        = ST_FULL;
                main_ld        = 1'b1;
                main_from_skid = 1'b1;
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
            main_ld = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            if (main_ld) main_q <= main_from_skid ? skid_q : up_entry;
            if (dn_vld && !dn.ready && !(&stall_q)) stall_q <= stall_q + 1'b1;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic skid_ld;
            assign skid_ld  = (state_q == ST_FULL) && up.valid && !dn.ready && !flush;
            // Ready depends on registered state only, so no combinational path from dn.ready.
            assign up.ready = (state_q != ST_SKID);
            always_ff @(posedge clk) begin
                if (reset)        skid_q <= '0;
                else if (skid_ld) skid_q <= up_entry;
            end
        end else begin : g_noskid
            assign up.ready = dn.ready | ~dn_vld;
            assign skid_q   = '0;
        end
    endgenerate

    assign dn.valid        = dn_vld;
    assign dn.data         = main_q[DATA_W-1:0];
    assign dn.rd           = main_q[DATA_W +: REG_ADDR_WIDTH];
    assign dn.reg_write_en = main_q[ENT_W-1] & dn_vld;
    assign occupancy       = state_q;
    assign stall_cnt       = stall_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: SKID=1 stage (CNT_W=4) and SKID=0 stage sharing clock/reset.
module tb_pipe_stage_skid;
    logic clk = 1'b0;
    logic reset;
    logic flush1, flush0;
    logic [1:0]  occ1, occ0;
    logic [3:0]  stall1;
    logic [15:0] stall0;
    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pipe_stage_skid_if #(.DATA_W(64), .REG_ADDR_WIDTH(5)) up1 ();
    pipe_stage_skid_if #(.DATA_W(64), .REG_ADDR_WIDTH(5)) dn1 ();
    pipe_stage_skid_if #(.DATA_W(64), .REG_ADDR_WIDTH(5)) up0 ();
    pipe_stage_skid_if #(.DATA_W(64), .REG_ADDR_WIDTH(5)) dn0 ();

    pipe_stage_skid #(.DATA_W(64), .REG_ADDR_WIDTH(5), .SKID(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .flush(flush1), .up(up1), .dn(dn1),
        .occupancy(occ1), .stall_cnt(stall1));

    pipe_stage_skid #(.DATA_W(64), .REG_ADDR_WIDTH(5), .SKID(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .flush(flush0), .up(up0), .dn(dn0),
        .occupancy(occ0), .stall_cnt(stall0));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic v, input logic [63:0] d, input logic rdy);
        up1.valid = v; up1.data = d; up1.rd = d[4:0]; up1.reg_write_en = v; dn1.ready = rdy;
    endtask

    initial begin
        reset = 1'b1; flush1 = 1'b0; flush0 = 1'b0;
        drive1(1'b1, 64'h55, 1'b1);
        up0.valid = 1'b0; up0.data = '0; up0.rd = '0; up0.reg_write_en = 1'b0; dn0.ready = 1'b0;
        tick; tick;
        reset = 1'b0;
        drive1(1'b0, 64'h0, 1'b0);
        #1;
        chk("rst_dn_valid", 64'(dn1.valid), 64'd0);
        chk("rst_dn_data", dn1.data, 64'd0);
        chk("rst_dn_rd", 64'(dn1.rd), 64'd0);
        chk("rst_dn_we", 64'(dn1.reg_write_en), 64'd0);
        chk("rst_occ", 64'(occ1), 64'd0);
        chk("rst_stall", 64'(stall1), 64'd0);
        chk("rst_up_ready", 64'(up1.ready), 64'd1);

        // Streaming 1..8 with downstream always ready
        for (int i = 1; i <= 8; i++) begin
            drive1(1'b1, 64'(i), 1'b1);
            tick;
            chk("strm_data", dn1.data, 64'(i));
            chk("strm_valid", 64'(dn1.valid), 64'd1);
            chk("strm_occ", 64'(occ1), 64'd1);
        end
        chk("strm_rd", 64'(dn1.rd), 64'd8);
        chk("strm_we", 64'(dn1.reg_write_en), 64'd1);
        drive1(1'b0, 64'h0, 1'b1);
        tick;
        chk("strm_drain_occ", 64'(occ1), 64'd0);
        chk("strm_drain_valid", 64'(dn1.valid), 64'd0);
        chk("strm_drain_we", 64'(dn1.reg_write_en), 64'd0);

        // Backpressure: 0xA then 0xB into a stalled stage
        drive1(1'b1, 64'hA, 1'b0);
        tick;
        chk("bp_a_data", dn1.data, 64'hA);
        chk("bp_a_occ", 64'(occ1), 64'd1);
        chk("bp_a_stall", 64'(stall1), 64'd0);
        chk("bp_a_up_ready", 64'(up1.ready), 64'd1);
        drive1(1'b1, 64'hB, 1'b0);
        tick;
        chk("bp_b_occ", 64'(occ1), 64'd2);
        chk("bp_b_up_ready", 64'(up1.ready), 64'd0);
        chk("bp_b_data", dn1.data, 64'hA);
        chk("bp_b_stall", 64'(stall1), 64'd1);
        drive1(1'b0, 64'h0, 1'b0);
        tick;
        chk("bp_hold_data", dn1.data, 64'hA);
        chk("bp_hold_stall", 64'(stall1), 64'd2);
        dn1.ready = 1'b1;
        tick;
        chk("bp_rel_data", dn1.data, 64'hB);
        chk("bp_rel_occ", 64'(occ1), 64'd1);
        chk("bp_rel_stall", 64'(stall1), 64'd2);
        tick;
        chk("bp_end_occ", 64'(occ1), 64'd0);

        // Flush while SKID_FULL with a new beat 0xC presented
        drive1(1'b1, 64'h1, 1'b0);
        tick;
        drive1(1'b1, 64'h2, 1'b0);
        tick;
        chk("fl_pre_occ", 64'(occ1), 64'd2);
        drive1(1'b1, 64'hC, 1'b0);
        flush1 = 1'b1;
        tick;
        flush1 = 1'b0;
        drive1(1'b0, 64'h0, 1'b1);
        chk("fl_valid", 64'(dn1.valid), 64'd0);
        chk("fl_we", 64'(dn1.reg_write_en), 64'd0);
        chk("fl_occ", 64'(occ1), 64'd0);
        chk("fl_stall_kept", 64'(stall1), 64'd4);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("fl_no_c", 64'(dn1.valid), 64'd0);
        end

        // Saturation of the 4-bit stall counter
        drive1(1'b1, 64'h7, 1'b0);
        tick;
        drive1(1'b0, 64'h0, 1'b0);
        chk("sat_start", 64'(stall1), 64'd4);
        for (int i = 0; i < 5; i++) tick;
        chk("sat_mid", 64'(stall1), 64'd9);
        for (int i = 0; i < 15; i++) tick;
        chk("sat_top", 64'(stall1), 64'd15);
        chk("sat_data", dn1.data, 64'h7);

        // Reset with two entries held
        drive1(1'b1, 64'h5, 1'b0);
        tick;
        chk("mrst_pre_occ", 64'(occ1), 64'd2);
        drive1(1'b0, 64'h0, 1'b0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("mrst_valid", 64'(dn1.valid), 64'd0);
        chk("mrst_occ", 64'(occ1), 64'd0);
        chk("mrst_stall", 64'(stall1), 64'd0);
        chk("mrst_up_ready", 64'(up1.ready), 64'd1);

        // SKID=0: ready follows dn_ready combinationally
        up0.valid = 1'b1; up0.data = 64'h11; up0.rd = 5'd3; up0.reg_write_en = 1'b1; dn0.ready = 1'b0;
        #1;
        chk("s0_empty_ready", 64'(up0.ready), 64'd1);
        tick;
        chk("s0_stall_ready", 64'(up0.ready), 64'd0);
        chk("s0_first_data", dn0.data, 64'h11);
        up0.data = 64'h22;
        tick;
        chk("s0_hold_data", dn0.data, 64'h11);
        chk("s0_hold_occ", 64'(occ0), 64'd1);
        chk("s0_stall_cnt", 64'(stall0), 64'd1);
        dn0.ready = 1'b1;
        #1;
        chk("s0_rel_ready", 64'(up0.ready), 64'd1);
        tick;
        chk("s0_rel_data", dn0.data, 64'h22);
        up0.data = 64'h33;
        tick;
        chk("s0_tput_data", dn0.data, 64'h33);
        chk("s0_tput_ready", 64'(up0.ready), 64'd1);
        up0.valid = 1'b0;
        tick;
        chk("s0_end_occ", 64'(occ0), 64'd0);
        chk("s0_end_we", 64'(dn0.reg_write_en), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
